fm24clxx_axis_master: RTL and testbench



---
 rtl/fm24clxx_pkg.sv | 27 ++
 rtl/fm24clxx_axis_master.sv | 180 ++++++++++++++++++
 tb/tb_fm24clxx_axis_master.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fm24clxx_pkg.sv
// Shared types for the FM24CLxx single-byte access sequencer.
// State encoding and the I2C command flag bundle.
package fm24clxx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W_CMD,
    W_ADDR,
    W_DATA,
    R_CMD_W,
    R_ADDR,
    R_CMD_R,
    R_DATA,
    DONE
  } state_t;

  localparam logic [3:0] FM24_DEV_CODE = 4'b1010;

  typedef struct packed {
    logic start;
    logic read;
    logic write;
    logic write_multiple;
    logic stop;
  } cmd_t;

endpackage

// File: rtl/fm24clxx_axis_master.sv
// FM24CLxx single-byte read/write sequencer driving an AXI-Stream I2C master.
// Outputs are registered from the next state so they track the FSM exactly.
module fm24clxx_axis_master
  import fm24clxx_pkg::*;
#(
  parameter int         FM24CLXX_TYPE = 2048,
  parameter logic [2:0] FM24CLXX_ADDR = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] mem_address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       write_enable,
  input  logic       read_enable,
  output logic       busy,
  output logic [6:0] s_axis_cmd_address,
  output logic       s_axis_cmd_start,
  output logic       s_axis_cmd_read,
  output logic       s_axis_cmd_write,
  output logic       s_axis_cmd_write_multiple,
  output logic       s_axis_cmd_stop,
  output logic       s_axis_cmd_valid,
  input  logic       s_axis_cmd_ready,
  output logic [7:0] s_axis_data_tdata,
  output logic       s_axis_data_tvalid,
  input  logic       s_axis_data_tready,
  output logic       s_axis_data_tlast,
  input  logic [7:0] m_axis_data_tdata,
  input  logic       m_axis_data_tvalid,
  output logic       m_axis_data_tready,
  input  logic       m_axis_data_tlast
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_dout;
  cmd_t       r_cmd;
  logic       r_cmd_valid;
  logic [7:0] r_tdata;
  logic       r_tvalid;
  logic       r_tlast;
  logic       r_mready;
  logic       r_busy;

  cmd_t       w_cmd;
  logic       w_cmd_valid;
  logic [7:0] w_tdata;
  logic       w_tvalid;
  logic       w_tlast;
  logic       w_mready;
  logic       w_busy;
  logic       w_unused;

  // Device size only documents the part; tlast from the core is not needed.
  assign w_unused = m_axis_data_tlast ^ (FM24CLXX_TYPE == 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_mready    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cmd       <= w_cmd;
      r_cmd_valid <= w_cmd_valid;
      r_tdata     <= w_tdata;
      r_tvalid    <= w_tvalid;
      r_tlast     <= w_tlast;
      r_mready    <= w_mready;
      r_busy      <= w_busy;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start && write_enable)
          w_next = W_CMD;
        else if (start && read_enable)
          w_next = R_CMD_W;
      end
      W_CMD:   if (r_cmd_valid && s_axis_cmd_ready) w_next = W_ADDR;
      W_ADDR:  if (r_tvalid && s_axis_data_tready) w_next = W_DATA;
      W_DATA:  if (r_tvalid && s_axis_data_tready) w_next = DONE;
      R_CMD_W: if (r_cmd_valid && s_axis_cmd_ready) w_next = R_ADDR;
      R_ADDR:  if (r_tvalid && s_axis_data_tready) w_next = R_CMD_R;
      R_CMD_R: if (r_cmd_valid && s_axis_cmd_ready) w_next = R_DATA;
      R_DATA:  if (r_mready && m_axis_data_tvalid) w_next = DONE;
      DONE:    if (!start) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_cmd       = '0;
    w_cmd_valid = 1'b0;
    w_tdata     = '0;
    w_tvalid    = 1'b0;
    w_tlast     = 1'b0;
    w_mready    = 1'b0;
    w_busy      = (w_next != IDLE) && (w_next != DONE);
    unique case (w_next)
      W_CMD: begin
        w_cmd_valid          = 1'b1;
        w_cmd.start          = 1'b1;
        w_cmd.write_multiple = 1'b1;
        w_cmd.stop           = 1'b1;
      end
      W_ADDR: begin
        w_tvalid = 1'b1;
        w_tdata  = r_addr;
      end
      W_DATA: begin
        w_tvalid = 1'b1;
        w_tdata  = r_wdata;
        w_tlast  = 1'b1;
      end
      R_CMD_W: begin
        w_cmd_valid = 1'b1;
        w_cmd.start = 1'b1;
        w_cmd.write = 1'b1;
      end
      R_ADDR: begin
        w_tvalid = 1'b1;
        w_tdata  = r_addr;
        w_tlast  = 1'b1;
      end
      R_CMD_R: begin
        w_cmd_valid = 1'b1;
        w_cmd.start = 1'b1;
        w_cmd.read  = 1'b1;
        w_cmd.stop  = 1'b1;
      end
      R_DATA:  w_mready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && w_next != IDLE) begin
      r_addr  <= mem_address;
      r_wdata <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_dout <= '0;
    else if (r_mready && m_axis_data_tvalid)
      r_dout <= m_axis_data_tdata;
  end

  assign s_axis_cmd_address        = {FM24_DEV_CODE, FM24CLXX_ADDR};
  assign s_axis_cmd_start          = r_cmd.start;
  assign s_axis_cmd_read           = r_cmd.read;
  assign s_axis_cmd_write          = r_cmd.write;
  assign s_axis_cmd_write_multiple = r_cmd.write_multiple;
  assign s_axis_cmd_stop           = r_cmd.stop;
  assign s_axis_cmd_valid          = r_cmd_valid;
  assign s_axis_data_tdata         = r_tdata;
  assign s_axis_data_tvalid        = r_tvalid;
  assign s_axis_data_tlast         = r_tlast;
  assign m_axis_data_tready        = r_mready;
  assign data_out                  = r_dout;
  assign busy                      = r_busy;

endmodule

// File: tb/tb_fm24clxx_axis_master.sv
// Bench for fm24clxx_axis_master: expected handshake list per request,
// random back-pressure, and directed reset/hold/no-enable cases.
module tb_fm24clxx_axis_master;

  localparam logic [1:0] EV_CMD = 2'd0;
  localparam logic [1:0] EV_WR  = 2'd1;
  localparam logic [1:0] EV_RD  = 2'd2;

  typedef struct packed {
    logic [1:0] k;
    logic [8:0] v;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] mem_address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       write_enable;
  logic       read_enable;
  logic       busy;
  logic [6:0] s_axis_cmd_address;
  logic       s_axis_cmd_start;
  logic       s_axis_cmd_read;
  logic       s_axis_cmd_write;
  logic       s_axis_cmd_write_multiple;
  logic       s_axis_cmd_stop;
  logic       s_axis_cmd_valid;
  logic       s_axis_cmd_ready;
  logic [7:0] s_axis_data_tdata;
  logic       s_axis_data_tvalid;
  logic       s_axis_data_tready;
  logic       s_axis_data_tlast;
  logic [7:0] m_axis_data_tdata;
  logic       m_axis_data_tvalid;
  logic       m_axis_data_tready;
  logic       m_axis_data_tlast;

  always #5 clk = ~clk;

  fm24clxx_axis_master dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .mem_address               (mem_address),
    .data_in                   (data_in),
    .data_out                  (data_out),
    .write_enable              (write_enable),
    .read_enable               (read_enable),
    .busy                      (busy),
    .s_axis_cmd_address        (s_axis_cmd_address),
    .s_axis_cmd_start          (s_axis_cmd_start),
    .s_axis_cmd_read           (s_axis_cmd_read),
    .s_axis_cmd_write          (s_axis_cmd_write),
    .s_axis_cmd_write_multiple (s_axis_cmd_write_multiple),
    .s_axis_cmd_stop           (s_axis_cmd_stop),
    .s_axis_cmd_valid          (s_axis_cmd_valid),
    .s_axis_cmd_ready          (s_axis_cmd_ready),
    .s_axis_data_tdata         (s_axis_data_tdata),
    .s_axis_data_tvalid        (s_axis_data_tvalid),
    .s_axis_data_tready        (s_axis_data_tready),
    .s_axis_data_tlast         (s_axis_data_tlast),
    .m_axis_data_tdata         (m_axis_data_tdata),
    .m_axis_data_tvalid        (m_axis_data_tvalid),
    .m_axis_data_tready        (m_axis_data_tready),
    .m_axis_data_tlast         (m_axis_data_tlast)
  );

  int checks = 0;
  int errors = 0;

  ev_t        q[$];
  ev_t        log_q[$];
  logic [7:0] exp_dout = 8'h00;
  bit         p_idle = 1'b1;
  bit         p_qe = 1'b1;
  bit         p_cv = 1'b0;
  bit         p_tv = 1'b0;
  logic [8:0] p_cf = '0;
  logic [8:0] p_td = '0;
  int         cmd_pct = 100;
  int         d_pct = 100;
  int         m_pct = 100;
  bit         force_m = 1'b0;
  logic [7:0] m_val = 8'h00;
  bit         rand_mode = 1'b0;
  bit         dir_go = 1'b0;
  bit         dir_we = 1'b0;
  bit         dir_re = 1'b0;
  logic [7:0] dir_a = 8'h00;
  logic [7:0] dir_d = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Flag order {start, read, write, write_multiple, stop}
  function automatic logic [8:0] flags(bit s, bit r, bit w, bit wm, bit st);
    return {4'b0, s, r, w, wm, st};
  endfunction

  task automatic issue(input bit w, input bit r, input logic [7:0] a,
                       input logic [7:0] d);
    start        = 1'b1;
    write_enable = w;
    read_enable  = r;
    mem_address  = a;
    data_in      = d;
    if (w) begin
      q.push_back('{EV_CMD, flags(1, 0, 0, 1, 1)});
      q.push_back('{EV_WR, {1'b0, a}});
      q.push_back('{EV_WR, {1'b1, d}});
    end else begin
      q.push_back('{EV_CMD, flags(1, 0, 1, 0, 0)});
      q.push_back('{EV_WR, {1'b1, a}});
      q.push_back('{EV_CMD, flags(1, 1, 0, 0, 1)});
      q.push_back('{EV_RD, 9'h0});
    end
  endtask

  task automatic cycle();
    bit         qe;
    bit         idle_now;
    bit         st_prev;
    ev_t        f;
    logic [8:0] cf;
    logic [8:0] td;
    logic [1:0] e;
    int         r;
    @(negedge clk);
    st_prev = start;
    qe = (q.size() == 0);
    f = qe ? '0 : q[0];
    cf = {4'b0, s_axis_cmd_start, s_axis_cmd_read, s_axis_cmd_write,
          s_axis_cmd_write_multiple, s_axis_cmd_stop};
    td = {s_axis_data_tlast, s_axis_data_tdata};
    chk("busy", busy, !qe);
    chk("data_out", data_out, exp_dout);
    chk("cmd_address", s_axis_cmd_address, 7'h50);
    chk("cmd_valid", s_axis_cmd_valid, !qe && f.k == EV_CMD);
    chk("data_tvalid", s_axis_data_tvalid, !qe && f.k == EV_WR);
    chk("m_tready", m_axis_data_tready, !qe && f.k == EV_RD);
    if (p_cv) chk("cmd_hold", cf, p_cf);
    if (p_tv) chk("data_hold", td, p_td);
    s_axis_cmd_ready   = ($urandom_range(99) < cmd_pct);
    s_axis_data_tready = ($urandom_range(99) < d_pct);
    m_axis_data_tvalid = ($urandom_range(99) < m_pct);
    m_axis_data_tdata  = force_m ? m_val : 8'($urandom);
    p_cv = s_axis_cmd_valid && !s_axis_cmd_ready;
    p_cf = cf;
    p_tv = s_axis_data_tvalid && !s_axis_data_tready;
    p_td = td;
    if (!qe && f.k == EV_CMD && s_axis_cmd_valid && s_axis_cmd_ready) begin
      chk("cmd_flags", cf, f.v);
      log_q.push_back('{EV_CMD, cf});
      void'(q.pop_front());
    end else if (!qe && f.k == EV_WR && s_axis_data_tvalid &&
                 s_axis_data_tready) begin
      chk("wr_byte", td, f.v);
      log_q.push_back('{EV_WR, td});
      void'(q.pop_front());
    end else if (!qe && f.k == EV_RD && m_axis_data_tready &&
                 m_axis_data_tvalid) begin
      exp_dout = m_axis_data_tdata;
      log_q.push_back('{EV_RD, {1'b0, m_axis_data_tdata}});
      void'(q.pop_front());
    end
    // Idle only after an edge seen in DONE/IDLE with start low.
    idle_now = qe && p_qe && (p_idle || !st_prev);
    if (idle_now && dir_go) begin
      issue(dir_we, dir_re, dir_a, dir_d);
      dir_go = 1'b0;
    end else if (rand_mode) begin
      if (idle_now) begin
        r = $urandom_range(99);
        if (r < 40) begin
          e = 2'($urandom_range(1, 3));
          issue(e[0], e[1], 8'($urandom), 8'($urandom));
        end else if (r < 55) begin
          start = 1'b1;
          write_enable = 1'b0;
          read_enable = 1'b0;
        end else begin
          start = 1'b0;
          write_enable = 1'($urandom_range(1));
          read_enable = 1'($urandom_range(1));
        end
      end else begin
        start = 1'($urandom_range(1));
        write_enable = 1'($urandom_range(1));
        read_enable = 1'($urandom_range(1));
      end
    end
    p_idle = idle_now;
    p_qe = qe;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && q.size() != 0; i++) cycle();
    chk("drain", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mem_address = 8'h00;
    data_in = 8'h00;
    write_enable = 1'b0;
    read_enable = 1'b0;
    s_axis_cmd_ready = 1'b0;
    s_axis_data_tready = 1'b0;
    m_axis_data_tdata = 8'h00;
    m_axis_data_tvalid = 1'b0;
    m_axis_data_tlast = 1'b1;

    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", s_axis_cmd_valid, 0);
    chk("rst_tvalid", s_axis_data_tvalid, 0);
    chk("rst_m_tready", m_axis_data_tready, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_cmd_address", s_axis_cmd_address, 7'h50);
    rst = 1'b0;

    // Write 0x04 <- 0xAA with stalled readies, then start held.
    cmd_pct = 0; d_pct = 0; m_pct = 0;
    log_q.delete();
    dir_we = 1; dir_re = 0; dir_a = 8'h04; dir_d = 8'hAA; dir_go = 1;
    cycle();
    repeat (4) cycle();
    cmd_pct = 100; d_pct = 100; m_pct = 100;
    drain(30);
    repeat (3) cycle();
    chk("wr_log_n", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("wr_log0", log_q[0].v, 9'h013);
      chk("wr_log1", log_q[1].v, 9'h004);
      chk("wr_log2", log_q[2].v, 9'h1AA);
    end
    chk("held_start_busy", busy, 0);
    start = 1'b0;
    cycle();

    // Random read from 0x04 returning 0xAA.
    log_q.delete();
    force_m = 1; m_val = 8'hAA;
    dir_we = 0; dir_re = 1; dir_a = 8'h04; dir_go = 1;
    cycle();
    drain(30);
    cycle();
    chk("rd_data_out", data_out, 8'hAA);
    chk("rd_log_n", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("rd_log0", log_q[0].v, 9'h014);
      chk("rd_log1", log_q[1].v, 9'h104);
      chk("rd_log2", log_q[2].v, 9'h019);
    end
    start = 1'b0; force_m = 0;
    cycle();

    // start without any enable.
    write_enable = 1'b0; read_enable = 1'b0; start = 1'b1;
    repeat (4) cycle();
    chk("noen_busy", busy, 0);
    chk("noen_cmd_valid", s_axis_cmd_valid, 0);
    start = 1'b0;
    cycle();

    // Reset asserted while the address byte is stalled.
    cmd_pct = 100; d_pct = 0;
    dir_we = 1; dir_re = 0; dir_a = 8'h33; dir_d = 8'h5C; dir_go = 1;
    for (int i = 0; i < 20 && !s_axis_data_tvalid; i++) cycle();
    chk("reach_waddr", s_axis_data_tvalid, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", s_axis_data_tvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_valid", s_axis_cmd_valid, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; write_enable = 1'b0;
    q.delete();
    exp_dout = 8'h00;
    p_idle = 1; p_qe = 1; p_cv = 0; p_tv = 0;
    log_q.delete();
    d_pct = 100;
    dir_we = 1; dir_re = 0; dir_a = 8'h33; dir_d = 8'h5C; dir_go = 1;
    cycle();
    drain(30);
    chk("restart_n", log_q.size(), 3);
    if (log_q.size() != 0) chk("restart_cmd", log_q[0].v, 9'h013);
    start = 1'b0;
    cycle();

    // Randomized traffic with varying back-pressure.
    rand_mode = 1;
    for (int blk = 0; blk < 15; blk++) begin
      cmd_pct = $urandom_range(20, 100);
      d_pct = $urandom_range(20, 100);
      m_pct = $urandom_range(20, 100);
      repeat (200) cycle();
    end
    rand_mode = 0;
    start = 1'b0;
    cmd_pct = 100; d_pct = 100; m_pct = 100;
    drain(50);
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
